tx_byte_feeder: RTL

TX_BYTE_FEEDER -- requirements
Module: tx_byte_feeder

---
 rtl/uart_link_pkg.sv | 19 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/tx_byte_feeder.sv | 96 +++++++++
 3 files changed

// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART/Hamming link blocks (TX, RX, byte feeder).
package uart_link_pkg;

   localparam int unsigned NIBBLE_W = 4;
   localparam int unsigned BYTE_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } feeder_state_e;

   // Upper nibble when hi is set, lower nibble otherwise.
   function automatic logic [NIBBLE_W-1:0] pick_nibble(input logic [BYTE_W-1:0] b,
                                                       input logic hi);
      return hi ? b[BYTE_W-1:NIBBLE_W] : b[NIBBLE_W-1:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push ignored when full, pop ignored when empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             push_ok_c, pop_ok_c;

   assign full      = (level_q == LW'(DEPTH));
   assign empty     = (level_q == '0);
   assign level     = level_q;
   assign dout      = mem[rd_ptr_q];
   assign push_ok_c = push && !full;
   assign pop_ok_c  = pop && !empty;

   // Pointers wrap at DEPTH; DEPTH is a power of two so the natural rollover is the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok_c, pop_ok_c})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok_c) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/tx_byte_feeder.sv
// Splits buffered bytes into nibbles and strobes them into the Hamming(7,4) TX encoder,
// one nibble every FRAME_CYCLES clocks.
module tx_byte_feeder
   import uart_link_pkg::*;
#(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned FRAME_CYCLES = 8,
   parameter int unsigned HI_FIRST     = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [BYTE_W-1:0]           in_data,
   output logic                        in_ready,
   output logic                        tx_load,
   output logic [NIBBLE_W-1:0]         tx_data,
   output logic                        busy,
   output logic [$clog2(DEPTH+1)-1:0]  level
);

   localparam int unsigned CW       = $clog2(FRAME_CYCLES);
   localparam logic        FIRST_HI = (HI_FIRST != 0);

   feeder_state_e         state_q;
   logic                  sel_q;        // 0: first nibble of head is next, 1: second
   logic [CW-1:0]         cnt_q;
   logic                  tx_load_q;
   logic [NIBBLE_W-1:0]   tx_data_q;

   logic [BYTE_W-1:0]     fifo_dout;
   logic                  fifo_full, fifo_empty;
   logic                  pop_c, frame_done_c, pending_c, enter_load_c;
   logic [NIBBLE_W-1:0]   next_nibble_c;

   sync_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (pop_c),
      .din   (in_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   // The head byte leaves the FIFO while its second nibble is being loaded.
   always_comb begin
      pop_c         = (state_q == LOAD) && sel_q;
      frame_done_c  = (cnt_q == CW'(FRAME_CYCLES - 2));
      pending_c     = sel_q || !fifo_empty;
      next_nibble_c = pick_nibble(fifo_dout, FIRST_HI ^ sel_q);
      enter_load_c  = ((state_q == IDLE) && !fifo_empty) ||
                      ((state_q == WAIT) && frame_done_c && pending_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= 1'b0;
         cnt_q     <= '0;
         tx_load_q <= 1'b0;
         tx_data_q <= '0;
      end else begin
         tx_load_q <= 1'b0;
         if (enter_load_c) begin
            state_q   <= LOAD;
            tx_load_q <= 1'b1;
            tx_data_q <= next_nibble_c;
         end else begin
            case (state_q)
               IDLE: state_q <= IDLE;
               LOAD: begin
                  state_q <= WAIT;
                  cnt_q   <= '0;
                  sel_q   <= ~sel_q;
               end
               WAIT: begin
                  if (frame_done_c) state_q <= IDLE;
                  else              cnt_q   <= cnt_q + CW'(1);
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign tx_load  = tx_load_q;
   assign tx_data  = tx_data_q;
   assign in_ready = !fifo_full;
   assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule
